// File: rtl/dma_pkg.sv
// Shared DMA datapath types: block-buffer phase and beat-packing mode encodings.
package dma_pkg;

    typedef enum logic [0:0] {
        BUF_FILL,
        BUF_DRAIN
    } buf_state_t;

    localparam logic MODE_WIDE   = 1'b0;
    localparam logic MODE_NARROW = 1'b1;

endpackage

// File: rtl/dma_buf_mem.sv
// Block storage: DEPTH x WIDTH register file, one write port with per-half enables,
// one asynchronous read port. Contents are not reset.
module dma_buf_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_lo,
    input  logic             we_hi,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned H = WIDTH / 2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_lo) mem[waddr][H-1:0]     <= wdata[H-1:0];
        if (we_hi) mem[waddr][WIDTH-1:H] <= wdata[WIDTH-1:H];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_block_buffer.sv
// Block buffer between the DMA read and write sides: fills a whole block (or up to a commit),
// then drains it completely before accepting new data. Supports two half-width beats per word.
module dma_block_buffer
    import dma_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             narrow,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             commit,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned H  = WIDTH / 2;

    if (WIDTH % 2 != 0 || WIDTH < 2) begin : g_bad_width
        $error("dma_block_buffer: WIDTH must be even and >= 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dma_block_buffer: DEPTH must be a power of 2 and >= 2");
    end

    buf_state_t       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             half_q, half_d;
    logic [LW-1:0]    level_q, level_d;
    logic             mode_q, mode_d;
    logic             fill_mode, word_done;
    logic             we_lo, we_hi;
    logic [WIDTH-1:0] wdata, rword;

    assign in_ready  = (state_q == BUF_FILL);
    assign out_valid = (state_q == BUF_DRAIN);
    assign full      = (state_q == BUF_DRAIN);
    assign empty     = (state_q == BUF_FILL) && (level_q == '0) && !half_q;
    assign level     = level_q;
    assign out_last  = out_valid && (level_q == LW'(1)) && (mode_q == MODE_WIDE || half_q);

    // The first beat of a block already obeys the incoming mode, since mode_q latches on it.
    assign fill_mode = empty ? narrow : mode_q;

    dma_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we_lo (we_lo),
        .we_hi (we_hi),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rword)
    );

    always_comb begin
        if (mode_q == MODE_NARROW) begin
            out_data = half_q ? {{H{1'b0}}, rword[WIDTH-1:H]} : {{H{1'b0}}, rword[H-1:0]};
        end else begin
            out_data = rword;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        half_d    = half_q;
        level_d   = level_q;
        mode_d    = empty ? narrow : mode_q;
        we_lo     = 1'b0;
        we_hi     = 1'b0;
        wdata     = '0;
        word_done = 1'b0;

        if (flush) begin
            state_d  = BUF_FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            half_d   = 1'b0;
            level_d  = '0;
        end else if (state_q == BUF_FILL) begin
            if (in_valid) begin
                if (fill_mode == MODE_WIDE) begin
                    we_lo     = 1'b1;
                    we_hi     = 1'b1;
                    wdata     = in_data;
                    word_done = 1'b1;
                end else if (!half_q) begin
                    // Clear the high half too, so a committed lone low half drains as zero.
                    we_lo  = 1'b1;
                    we_hi  = 1'b1;
                    wdata  = {{H{1'b0}}, in_data[H-1:0]};
                    half_d = 1'b1;
                end else begin
                    we_hi     = 1'b1;
                    wdata     = {in_data[H-1:0], {H{1'b0}}};
                    half_d    = 1'b0;
                    word_done = 1'b1;
                end
            end
            if (word_done) begin
                level_d  = level_q + LW'(1);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (commit && half_d) begin
                level_d = level_d + LW'(1);
            end
            if ((word_done && wr_ptr_q == AW'(DEPTH - 1)) || (commit && level_d != '0)) begin
                state_d  = BUF_DRAIN;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                half_d   = 1'b0;
            end
        end else if (out_ready) begin
            if (mode_q == MODE_WIDE || half_q) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                level_d  = level_q - LW'(1);
                half_d   = 1'b0;
                if (out_last) begin
                    state_d  = BUF_FILL;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                end
            end else begin
                half_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= BUF_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            half_q   <= 1'b0;
            level_q  <= '0;
            mode_q   <= MODE_WIDE;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            half_q   <= half_d;
            level_q  <= level_d;
            mode_q   <= mode_d;
        end
    end

endmodule

// File: tb/tb_dma_block_buffer.sv
// Scoreboard bench for dma_block_buffer: expected beats queued at fill time, checked on drain.
module tb_dma_block_buffer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             resetn, narrow, in_valid, in_ready, commit, flush;
    logic             out_valid, out_ready, out_last, empty, full;
    logic [WIDTH-1:0] in_data, out_data;
    logic [LW-1:0]    level;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;

    dma_block_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .narrow    (narrow),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .commit    (commit),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .level     (level),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_all(input int exp_cycles);
        int cycles = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && cycles < 50) begin
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        check_eq("drain_queue_left", 32'(sb.size()), 32'd0);
        check_eq("drain_cycles", 32'(cycles), 32'(exp_cycles));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_last"}, 32'(out_last), 32'd0);
        check_eq({tag, "_level"}, 32'(level), 32'd0);
        check_eq({tag, "_empty"}, 32'(empty), 32'd1);
        check_eq({tag, "_full"}, 32'(full), 32'd0);
    endtask

    // Output monitor: compare every transferred beat against the scoreboard head.
    always @(negedge clk) begin
        if (resetn && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                beat_t b;
                b = sb.pop_front();
                check_eq("out_data", 32'(out_data), 32'(b.data));
                check_eq("out_last", 32'(out_last), 32'(b.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; narrow = 1'b0; in_valid = 1'b0; in_data = '0;
        commit = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        resetn = 1'b1;

        // Wide full block
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h10 + i), i == 7);
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            tick();
        end
        in_valid = 1'b0;
        check_eq("wide_in_ready", 32'(in_ready), 32'd0);
        check_eq("wide_full", 32'(full), 32'd1);
        check_eq("wide_level", 32'(level), 32'd8);
        check_eq("wide_out_valid", 32'(out_valid), 32'd1);
        drain_all(8);
        check_idle("wide_done");

        // Narrow block: 16 nibbles, 16 truncates to 0
        narrow = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push(8'(i % 16), i == 16);
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check_eq("narrow_level", 32'(level), 32'd8);
        check_eq("narrow_full", 32'(full), 32'd1);
        drain_all(16);
        check_idle("narrow_done");
        narrow = 1'b0;

        // Partial commit
        push(8'hA1, 1'b0); send(8'hA1);
        push(8'hA2, 1'b0); send(8'hA2);
        push(8'hA3, 1'b1); send(8'hA3);
        check_eq("partial_pre_level", 32'(level), 32'd3);
        check_eq("partial_pre_in_ready", 32'(in_ready), 32'd1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check_eq("partial_out_valid", 32'(out_valid), 32'd1);
        check_eq("partial_level", 32'(level), 32'd3);
        drain_all(3);
        check_idle("partial_done");

        // Commit in the same cycle as a beat includes that beat
        push(8'h41, 1'b0); send(8'h41);
        push(8'h42, 1'b1);
        in_valid = 1'b1; in_data = 8'h42; commit = 1'b1;
        tick();
        in_valid = 1'b0; commit = 1'b0;
        check_eq("commit_beat_level", 32'(level), 32'd2);
        drain_all(2);

        // Narrow half commit: stale high nibble in word 0 must read as zero
        narrow = 1'b1;
        push(8'h05, 1'b0);
        push(8'h00, 1'b1);
        send(8'h05);
        check_eq("half_level_pending", 32'(level), 32'd0);
        check_eq("half_empty_pending", 32'(empty), 32'd0);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check_eq("half_commit_level", 32'(level), 32'd1);
        drain_all(2);
        check_idle("half_done");
        narrow = 1'b0;

        // Backpressure then flush mid-drain
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i));
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_out_data", 32'(out_data), 32'h30);
            check_eq("bp_level", 32'(level), 32'd8);
        end
        push(8'h30, 1'b0);
        push(8'h31, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("bp_queue_left", 32'(sb.size()), 32'd0);
        check_eq("bp_out_data_after", 32'(out_data), 32'h32);
        check_eq("bp_level_after", 32'(level), 32'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush");

        // Reset mid-fill
        for (int i = 0; i < 4; i++) send(8'(8'h50 + i));
        check_eq("prereset_level", 32'(level), 32'd4);
        resetn = 1'b0;
        tick();
        check_idle("midreset");
        check_eq("midreset_out_data", 32'(out_data), 32'h50);
        resetn = 1'b1;

        // Commit while empty is ignored
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check_idle("empty_commit");

        // in_valid and commit in DRAIN are ignored
        push(8'h61, 1'b0); send(8'h61);
        push(8'h62, 1'b1); send(8'h62);
        commit = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 8'hEE;
        tick();
        tick();
        in_valid = 1'b0; commit = 1'b0;
        check_eq("drain_ignore_level", 32'(level), 32'd2);
        check_eq("drain_ignore_in_ready", 32'(in_ready), 32'd0);
        check_eq("drain_ignore_out_data", 32'(out_data), 32'h61);
        drain_all(2);
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_block_buffer.md
# dma_block_buffer

Parametrised block buffer for the DMA datapath, sitting between the address/length FSM's read side and its write side. It fills completely, or until a commit, from the input stream, then drains the whole block to the output stream before accepting new data. It supports full-width beats or half-width beats packed two per word, early commit of partial blocks, flush, and an occupancy count.

## Interface
- WIDTH, 8, word width in bits; must be even and ≥ 2.
- DEPTH, 8, words per block; must be a power of 2 and ≥ 2.
- LW, $clog2(DEPTH)+1, width of `level`; derived, not overridable.

- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- narrow  in  1  0 = full-width beats; 1 = half-width beats in bits [WIDTH/2-1:0].
- in_valid  in  1  input beat valid.
- in_data  in  WIDTH  input beat.
- in_ready  out  1  buffer accepts input (FILL phase).
- commit  in  1  end FILL early and drain what is held.
- flush  in  1  discard contents and return to empty FILL.
- out_valid  out  1  output beat valid (DRAIN phase).
- out_data  out  WIDTH  output beat; upper half is zero in narrow mode.
- out_ready  in  1  consumer takes beat.
- out_last  out  1  current output beat is the final beat of the block.
- level  out  LW  complete words resident.
- empty  out  1  FILL phase, level==0, no pending half-word.
- full  out  1  DRAIN phase.

## Operation
- States: FILL and DRAIN. Reset and flush enter FILL with wr_ptr=rd_ptr=0, half=0, level=0.
- Reset values: in_ready=1, out_valid=0, out_last=0, level=0, empty=1, full=0, out_data=mem[0] (memory is not reset).
- Priority: resetn, then flush, then commit, then beat transfer. On a flush cycle no beat is accepted or transferred.
- Mode: `narrow` is latched into mode_q whenever empty=1. mode_q governs the entire block. Changes to `narrow` mid-block are ignored.
- FILL, wide mode: on in_valid & in_ready, mem[wr_ptr]<=in_data, wr_ptr++, level++.
- FILL, narrow mode:
  - When half=0: write low half, set half=1.
  - When half=1: write high half, wr_ptr++, level++, set half=0.
- FILL → DRAIN when the word at wr_ptr==DEPTH-1 completes. The drain count is DEPTH.
- commit in FILL:
  - If the resulting level>0 or half=1, go to DRAIN. A beat accepted in the same cycle is included.
  - A pending low half is committed as a word whose high half is zero. It counts in `level`.
  - If the buffer is empty, commit is ignored.
- DRAIN, wide mode: out_data=mem[rd_ptr]. On out_valid & out_ready, rd_ptr++, level--.
- DRAIN, narrow mode:
  - half=0 presents the low half, zero-extended.
  - half=1 presents the high half. The word retires (rd_ptr++, level--) after its high half.
- out_last=1 on the last beat of the block: the last word in wide mode, or its high half in narrow mode.
- DRAIN → FILL after the last beat transfers. Pointers and half reset to 0.
- commit in DRAIN is ignored. in_valid in DRAIN is ignored (in_ready=0).

## Timing
- in_ready, out_valid, out_last, level, empty and full are decoded from registered state only. There is no combinational path from in_valid/out_ready.
- out_data is an asynchronous read of mem[rd_ptr] plus the half select. It is valid in the same cycle out_valid rises.
- Fill-to-drain turnaround: when the final word or commit lands in cycle N, out_valid=1 in cycle N+1.
- Drain-to-fill turnaround: when the last beat transfers in cycle M, in_ready=1 in cycle M+1.
- Throughput is 1 beat/clk in both phases.
- Reset mid-block drops all data. Outputs take their reset values in the next cycle.

## Structure
- Shared package dma_pkg:
  - typedef buf_state_t {BUF_FILL, BUF_DRAIN}.
  - Constants MODE_WIDE=1'b0, MODE_NARROW=1'b1.
- Sub-module dma_buf_mem: DEPTH×WIDTH register file with one write port, two half-word write enables, and one asynchronous read port.
- Control FSM, pointers, half flag and level counter live in dma_block_buffer.
- Elaboration-time checks: WIDTH even; DEPTH a power of 2.

## Test plan
- Wide full block: WIDTH=8, DEPTH=8, write 0x10..0x17 back-to-back → in_ready drops the cycle after the 8th beat; out 0x10..0x17 at 1/clk; out_last only on 0x17; level 8→0.
- Narrow block: narrow=1, write nibbles 1,2,3,…,16 (low 4 bits) → 16 out beats 0x01,0x02,…,0x0F,0x00 (16 truncates to 0); level peaks at 8; out_last on the 16th beat.
- Partial commit: write 0xA1,0xA2,0xA3, then commit → DRAIN with level=3; outputs 0xA1,0xA2,0xA3; out_last on 0xA3; returns to FILL, empty=1.
- Narrow half commit: narrow=1, write nibble 0x5, then commit → one word; out beats 0x05, 0x00; out_last on the second.
- Backpressure and flush: during DRAIN hold out_ready=0 for 3 clks → out_data is stable and rd_ptr does not move; assert flush mid-drain → next cycle in_ready=1, level=0, empty=1, out_valid=0.
- Reset mid-fill and ignored inputs: resetn=0 after 4 beats → all outputs at reset values; commit while empty and in_valid during DRAIN change nothing.
